// File: rtl/mips_run_controller.sv
// mips_run_controller: timed core reset release, run-cycle counting, halt (PC stuck) and timeout detection
module mips_run_controller #(
    parameter int PC_WIDTH     = 32,
    parameter int CNT_WIDTH    = 32,
    parameter int RESET_CYCLES = 4,
    parameter int HALT_REPEAT  = 3,
    parameter int MAX_CYCLES   = 10000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [PC_WIDTH-1:0]  pc,
    input  logic                 pc_valid,
    output logic                 core_reset,
    output logic                 run_active,
    output logic                 done,
    output logic                 timeout,
    output logic [PC_WIDTH-1:0]  halt_pc,
    output logic [CNT_WIDTH-1:0] cycle_count
);
    localparam int HW = $clog2(RESET_CYCLES + 1);
    localparam int SW = $clog2(HALT_REPEAT + 1);

    typedef enum logic [2:0] {IDLE, HOLD, RUN, DONE, TIMEOUT} state_t;

    state_t               state, state_n;
    logic [HW-1:0]        hold_cnt, hold_n;
    logic [SW-1:0]        stable_cnt, stable_n;
    logic [PC_WIDTH-1:0]  last_pc, last_n, halt_pc_n;
    logic                 have_pc, have_n, done_n, timeout_n, halt;
    logic [CNT_WIDTH-1:0] cnt_n;

    always_comb begin
        state_n   = state;
        hold_n    = hold_cnt;
        stable_n  = stable_cnt;
        last_n    = last_pc;
        have_n    = have_pc;
        done_n    = done;
        timeout_n = timeout;
        halt_pc_n = halt_pc;
        cnt_n     = cycle_count;
        halt      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = HOLD;
                    hold_n  = '0;
                end
            end
            HOLD: begin
                // one extra edge after the counter fills gives start->release of RESET_CYCLES+1 edges
                if (hold_cnt == HW'(RESET_CYCLES)) state_n = RUN;
                else hold_n = hold_cnt + 1'b1;
            end
            RUN: begin
                cnt_n = cycle_count + 1'b1;
                if (pc_valid) begin
                    if (!have_pc) begin
                        last_n = pc;
                        have_n = 1'b1;
                    end else if (pc == last_pc) begin
                        if (stable_cnt == SW'(HALT_REPEAT - 1)) halt = 1'b1;
                        else stable_n = stable_cnt + 1'b1;
                    end else begin
                        stable_n = '0;
                        last_n   = pc;
                    end
                end
                if (halt) begin
                    state_n   = DONE;
                    done_n    = 1'b1;
                    halt_pc_n = pc;
                end else if (cnt_n == CNT_WIDTH'(MAX_CYCLES)) begin
                    state_n   = TIMEOUT;
                    timeout_n = 1'b1;
                end
            end
            DONE, TIMEOUT: begin
                if (start) begin
                    state_n   = HOLD;
                    hold_n    = '0;
                    done_n    = 1'b0;
                    timeout_n = 1'b0;
                    cnt_n     = '0;
                    stable_n  = '0;
                    have_n    = 1'b0;
                    last_n    = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            stable_cnt  <= '0;
            last_pc     <= '0;
            have_pc     <= 1'b0;
            core_reset  <= 1'b1;
            run_active  <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            halt_pc     <= '0;
            cycle_count <= '0;
        end else begin
            state       <= state_n;
            hold_cnt    <= hold_n;
            stable_cnt  <= stable_n;
            last_pc     <= last_n;
            have_pc     <= have_n;
            core_reset  <= state_n != RUN;
            run_active  <= state_n == RUN;
            done        <= done_n;
            timeout     <= timeout_n;
            halt_pc     <= halt_pc_n;
            cycle_count <= cnt_n;
        end
    end
endmodule

// File: tb/tb_mips_run_controller.sv
// tb_mips_run_controller: directed checks of reset release, halt, timeout and reset-abort
module tb_mips_run_controller;
    logic        clk = 1'b0;
    logic        reset, start, pc_valid;
    logic [31:0] pc;
    logic        core_reset, run_active, done, timeout;
    logic [31:0] halt_pc, cycle_count;
    int          total = 0, bad = 0;

    mips_run_controller #(
        .PC_WIDTH(32), .CNT_WIDTH(32), .RESET_CYCLES(4), .HALT_REPEAT(3), .MAX_CYCLES(16)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .pc(pc), .pc_valid(pc_valid),
        .core_reset(core_reset), .run_active(run_active), .done(done), .timeout(timeout),
        .halt_pc(halt_pc), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic launch();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("hold_done_clr", done, 0);
        check("hold_core_reset", core_reset, 1);
        repeat (5) tick();
        check("run_active", run_active, 1);
        check("run_core_reset", core_reset, 0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b1; pc = '0; pc_valid = 1'b0;
        repeat (2) tick();
        check("rst_core_reset", core_reset, 1);
        check("rst_done", done, 0);
        check("rst_timeout", timeout, 0);
        check("rst_run_active", run_active, 0);
        check("rst_cycle_count", cycle_count, 0);
        check("rst_halt_pc", halt_pc, 0);
        reset = 1'b1; start = 1'b0;
        tick();
        check("idle_core_reset", core_reset, 1);
        // release timing: start at edge t, core_reset held through t+4, low after t+5
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check($sformatf("hold_edge%0d", i), core_reset, 1);
            check($sformatf("hold_run%0d", i), run_active, 0);
        end
        tick();
        check("release_core_reset", core_reset, 0);
        check("release_run_active", run_active, 1);
        // halt after three repeats of 0x20
        begin
            logic [31:0] seq [7] = '{32'h0, 32'h4, 32'h8, 32'h20, 32'h20, 32'h20, 32'h20};
            pc_valid = 1'b1;
            for (int i = 0; i < 7; i++) begin
                pc = seq[i];
                tick();
                if (i < 6) check($sformatf("halt_pending%0d", i), done, 0);
            end
        end
        check("halt_done", done, 1);
        check("halt_pc", halt_pc, 32'h20);
        check("halt_core_reset", core_reset, 1);
        check("halt_run_active", run_active, 0);
        check("halt_count", cycle_count, 7);
        tick();
        check("done_sticky", done, 1);
        check("count_hold", cycle_count, 7);
        // timeout with steadily moving pc
        launch();
        for (int i = 0; i < 16; i++) begin
            pc = 32'h100 + 4 * i;
            tick();
            if (i == 14) begin
                check("to_pending", timeout, 0);
                check("to_count15", cycle_count, 15);
            end
        end
        check("to_timeout", timeout, 1);
        check("to_count", cycle_count, 16);
        check("to_done", done, 0);
        check("to_core_reset", core_reset, 1);
        check("to_halt_pc_kept", halt_pc, 32'h20);
        tick();
        check("to_count_hold", cycle_count, 16);
        // halt and budget exhaustion on the same edge: done wins
        launch();
        check("restart_timeout_clr", timeout, 0);
        check("restart_count_clr", cycle_count, 0);
        for (int i = 0; i < 16; i++) begin
            pc = (i < 12) ? 32'h200 + 4 * i : 32'h40;
            tick();
        end
        check("tie_done", done, 1);
        check("tie_timeout", timeout, 0);
        check("tie_count", cycle_count, 16);
        check("tie_halt_pc", halt_pc, 32'h40);
        // invalid gaps between repeats do not break halt detection
        launch();
        for (int i = 0; i < 7; i++) begin
            pc_valid = (i % 2 == 0);
            pc = pc_valid ? 32'h40 : 32'hdead_beef;
            tick();
            if (i < 6) check($sformatf("gap_pending%0d", i), done, 0);
        end
        check("gap_done", done, 1);
        check("gap_count", cycle_count, 7);
        // reset in the middle of a run
        launch();
        pc_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pc = 32'h300 + 4 * i;
            tick();
        end
        check("mid_count", cycle_count, 3);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("abort_core_reset", core_reset, 1);
        check("abort_run_active", run_active, 0);
        check("abort_count", cycle_count, 0);
        check("abort_done", done, 0);
        check("abort_halt_pc", halt_pc, 0);
        launch();
        for (int i = 0; i < 4; i++) begin
            pc = 32'h80;
            tick();
        end
        check("rerun_done", done, 1);
        check("rerun_count", cycle_count, 4);
        check("rerun_halt_pc", halt_pc, 32'h80);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
